// File: rtl/reservation_station_param_pkg.sv
// Shared defaults for the ALU reservation station slice.
package reservation_station_param_pkg;

  localparam int DEF_RS_SIZE   = 16;
  localparam int DEF_ROB_IDX_W = 5;
  localparam int DEF_DATA_W    = 32;
  localparam int DEF_OP_W      = 6;
  localparam int DEF_NUM_CDB   = 2;

endpackage

// File: rtl/reservation_station_param_if.sv
// Issue, result-broadcast and dispatch bundle between issue logic, CDBs, the ALU and the station.
interface reservation_station_param_if
  import reservation_station_param_pkg::*;
#(
  parameter int RS_SIZE   = DEF_RS_SIZE,
  parameter int ROB_IDX_W = DEF_ROB_IDX_W,
  parameter int DATA_W    = DEF_DATA_W,
  parameter int OP_W      = DEF_OP_W,
  parameter int NUM_CDB   = DEF_NUM_CDB
);

  logic                          issue_valid;
  logic [ROB_IDX_W-1:0]          issue_rob_index;
  logic [OP_W-1:0]               issue_op;
  logic [DATA_W-1:0]             issue_rs1_val;
  logic [ROB_IDX_W-1:0]          issue_rs1_depend;
  logic [DATA_W-1:0]             issue_rs2_val;
  logic [ROB_IDX_W-1:0]          issue_rs2_depend;
  logic [DATA_W-1:0]             issue_imm;
  logic [DATA_W-1:0]             issue_PC;

  logic [NUM_CDB-1:0]            cdb_valid;
  logic [NUM_CDB*ROB_IDX_W-1:0]  cdb_rob_index;
  logic [NUM_CDB*DATA_W-1:0]     cdb_result;

  logic                          out_valid;
  logic                          out_ready;
  logic [OP_W-1:0]               out_op;
  logic [DATA_W-1:0]             out_rs1;
  logic [DATA_W-1:0]             out_rs2;
  logic [DATA_W-1:0]             out_imm;
  logic [DATA_W-1:0]             out_PC;
  logic [ROB_IDX_W-1:0]          out_rob_index;

  logic                          rs_full;
  logic [$clog2(RS_SIZE+1)-1:0]  rs_count;

  modport master (
    output issue_valid, issue_rob_index, issue_op, issue_rs1_val, issue_rs1_depend,
           issue_rs2_val, issue_rs2_depend, issue_imm, issue_PC,
           cdb_valid, cdb_rob_index, cdb_result, out_ready,
    input  out_valid, out_op, out_rs1, out_rs2, out_imm, out_PC, out_rob_index,
           rs_full, rs_count
  );

  modport slave (
    input  issue_valid, issue_rob_index, issue_op, issue_rs1_val, issue_rs1_depend,
           issue_rs2_val, issue_rs2_depend, issue_imm, issue_PC,
           cdb_valid, cdb_rob_index, cdb_result, out_ready,
    output out_valid, out_op, out_rs1, out_rs2, out_imm, out_PC, out_rob_index,
           rs_full, rs_count
  );

endinterface

// File: rtl/reservation_station_param_age_select.sv
// Oldest-ready picker: grants the ready entry that no other ready entry is older than.
module rs_age_select
  import reservation_station_param_pkg::*;
#(
  parameter int N = DEF_RS_SIZE
) (
  input  logic [N-1:0]   ready_i,
  input  logic [N*N-1:0] older_i,
  output logic [N-1:0]   grant_o,
  output logic           anyReady_o
);

  logic [N-1:0] blocked;

  // Bit j*N+i of older_i set means entry j was issued before entry i.
  always_comb begin
    blocked = '0;
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        if (ready_i[j] && older_i[j*N+i]) begin
          blocked[i] = 1'b1;
        end
      end
    end
    grant_o    = ready_i & ~blocked;
    anyReady_o = |ready_i;
  end

endmodule

// File: rtl/reservation_station_param.sv
// ALU reservation station: holds issued ops, snoops NUM_CDB result buses, dispatches the oldest ready entry.
module reservation_station_param
  import reservation_station_param_pkg::*;
#(
  parameter int RS_SIZE   = DEF_RS_SIZE,
  parameter int ROB_IDX_W = DEF_ROB_IDX_W,
  parameter int DATA_W    = DEF_DATA_W,
  parameter int OP_W      = DEF_OP_W,
  parameter int NUM_CDB   = DEF_NUM_CDB
) (
  input logic clk_in,
  input logic rst_in,
  input logic rdy_in,
  input logic clr_in,
  reservation_station_param_if.slave bus
);

  localparam int CNT_W = $clog2(RS_SIZE+1);

  logic [RS_SIZE-1:0]         busy_q, busy_d;
  logic [RS_SIZE*RS_SIZE-1:0] older_q, older_d;
  logic [CNT_W-1:0]           count_q, count_d;

  logic [OP_W-1:0]      op_q[RS_SIZE],     op_d[RS_SIZE];
  logic [ROB_IDX_W-1:0] rob_q[RS_SIZE],    rob_d[RS_SIZE];
  logic [DATA_W-1:0]    rs1Val_q[RS_SIZE], rs1Val_d[RS_SIZE];
  logic [ROB_IDX_W-1:0] rs1Dep_q[RS_SIZE], rs1Dep_d[RS_SIZE];
  logic [DATA_W-1:0]    rs2Val_q[RS_SIZE], rs2Val_d[RS_SIZE];
  logic [ROB_IDX_W-1:0] rs2Dep_q[RS_SIZE], rs2Dep_d[RS_SIZE];
  logic [DATA_W-1:0]    imm_q[RS_SIZE],    imm_d[RS_SIZE];
  logic [DATA_W-1:0]    pc_q[RS_SIZE],     pc_d[RS_SIZE];

  logic                 outValid_q, outValid_d;
  logic [OP_W-1:0]      outOp_q, outOp_d;
  logic [DATA_W-1:0]    outRs1_q, outRs1_d;
  logic [DATA_W-1:0]    outRs2_q, outRs2_d;
  logic [DATA_W-1:0]    outImm_q, outImm_d;
  logic [DATA_W-1:0]    outPc_q, outPc_d;
  logic [ROB_IDX_W-1:0] outRob_q, outRob_d;

  logic [RS_SIZE-1:0] readyVec, grant, freeOh;
  logic               anyReady, freeFound, rsFull, issueAcc, doDispatch;
  logic [OP_W-1:0]      selOp;
  logic [ROB_IDX_W-1:0] selRob;
  logic [DATA_W-1:0]    selRs1, selRs2, selImm, selPc;

  // Resolves one operand against all CDB channels; scanning high to low lets channel 0 win duplicates.
  function automatic logic [ROB_IDX_W+DATA_W-1:0] resolve(
    input logic [ROB_IDX_W-1:0]         dep,
    input logic [DATA_W-1:0]            val,
    input logic [NUM_CDB-1:0]           cv,
    input logic [NUM_CDB*ROB_IDX_W-1:0] ct,
    input logic [NUM_CDB*DATA_W-1:0]    cr
  );
    logic [ROB_IDX_W-1:0] d;
    logic [DATA_W-1:0]    v;
    d = dep;
    v = val;
    for (int k = NUM_CDB-1; k >= 0; k--) begin
      if (cv[k] && (dep != '0) && (dep == ct[k*ROB_IDX_W +: ROB_IDX_W])) begin
        d = '0;
        v = cr[k*DATA_W +: DATA_W];
      end
    end
    return {d, v};
  endfunction

  assign rsFull     = &busy_q;
  assign issueAcc   = rdy_in && bus.issue_valid && !rsFull;
  assign doDispatch = rdy_in && (!outValid_q || bus.out_ready) && anyReady;

  always_comb begin
    readyVec  = '0;
    freeOh    = '0;
    freeFound = 1'b0;
    for (int i = 0; i < RS_SIZE; i++) begin
      readyVec[i] = busy_q[i] && (rs1Dep_q[i] == '0) && (rs2Dep_q[i] == '0);
      if (!busy_q[i] && !freeFound) begin
        freeOh[i] = 1'b1;
        freeFound = 1'b1;
      end
    end
  end

  rs_age_select #(.N(RS_SIZE)) uAgeSelect (
    .ready_i    (readyVec),
    .older_i    (older_q),
    .grant_o    (grant),
    .anyReady_o (anyReady)
  );

  always_comb begin
    selOp  = '0;
    selRob = '0;
    selRs1 = '0;
    selRs2 = '0;
    selImm = '0;
    selPc  = '0;
    for (int i = 0; i < RS_SIZE; i++) begin
      if (grant[i]) begin
        selOp  = op_q[i];
        selRob = rob_q[i];
        selRs1 = rs1Val_q[i];
        selRs2 = rs2Val_q[i];
        selImm = imm_q[i];
        selPc  = pc_q[i];
      end
    end
  end

  always_comb begin
    busy_d     = busy_q;
    older_d    = older_q;
    outValid_d = outValid_q;
    outOp_d    = outOp_q;
    outRob_d   = outRob_q;
    outRs1_d   = outRs1_q;
    outRs2_d   = outRs2_q;
    outImm_d   = outImm_q;
    outPc_d    = outPc_q;
    for (int i = 0; i < RS_SIZE; i++) begin
      op_d[i]  = op_q[i];
      rob_d[i] = rob_q[i];
      imm_d[i] = imm_q[i];
      pc_d[i]  = pc_q[i];
      {rs1Dep_d[i], rs1Val_d[i]} = resolve(rs1Dep_q[i], rs1Val_q[i],
                                           bus.cdb_valid, bus.cdb_rob_index, bus.cdb_result);
      {rs2Dep_d[i], rs2Val_d[i]} = resolve(rs2Dep_q[i], rs2Val_q[i],
                                           bus.cdb_valid, bus.cdb_rob_index, bus.cdb_result);
    end
    // New entry is younger than every busy entry and older than none.
    for (int v = 0; v < RS_SIZE; v++) begin
      if (issueAcc && freeOh[v]) begin
        busy_d[v] = 1'b1;
        op_d[v]   = bus.issue_op;
        rob_d[v]  = bus.issue_rob_index;
        imm_d[v]  = bus.issue_imm;
        pc_d[v]   = bus.issue_PC;
        {rs1Dep_d[v], rs1Val_d[v]} = resolve(bus.issue_rs1_depend, bus.issue_rs1_val,
                                             bus.cdb_valid, bus.cdb_rob_index, bus.cdb_result);
        {rs2Dep_d[v], rs2Val_d[v]} = resolve(bus.issue_rs2_depend, bus.issue_rs2_val,
                                             bus.cdb_valid, bus.cdb_rob_index, bus.cdb_result);
        for (int j = 0; j < RS_SIZE; j++) begin
          older_d[j*RS_SIZE+v] = busy_q[j];
        end
        for (int j = 0; j < RS_SIZE; j++) begin
          older_d[v*RS_SIZE+j] = 1'b0;
        end
      end
    end
    if (doDispatch) begin
      busy_d     = busy_d & ~grant;
      outValid_d = 1'b1;
      outOp_d    = selOp;
      outRob_d   = selRob;
      outRs1_d   = selRs1;
      outRs2_d   = selRs2;
      outImm_d   = selImm;
      outPc_d    = selPc;
    end else if (bus.out_ready) begin
      outValid_d = 1'b0;
    end
    count_d = count_q + CNT_W'(issueAcc) - CNT_W'(doDispatch);
  end

  // Flush has the same effect as reset and overrides everything else in that cycle.
  always_ff @(posedge clk_in) begin
    if (rst_in || clr_in) begin
      busy_q     <= '0;
      older_q    <= '0;
      count_q    <= '0;
      outValid_q <= 1'b0;
    end else if (rdy_in) begin
      busy_q     <= busy_d;
      older_q    <= older_d;
      count_q    <= count_d;
      outValid_q <= outValid_d;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rdy_in) begin
      outOp_q  <= outOp_d;
      outRob_q <= outRob_d;
      outRs1_q <= outRs1_d;
      outRs2_q <= outRs2_d;
      outImm_q <= outImm_d;
      outPc_q  <= outPc_d;
      for (int i = 0; i < RS_SIZE; i++) begin
        op_q[i]     <= op_d[i];
        rob_q[i]    <= rob_d[i];
        rs1Val_q[i] <= rs1Val_d[i];
        rs1Dep_q[i] <= rs1Dep_d[i];
        rs2Val_q[i] <= rs2Val_d[i];
        rs2Dep_q[i] <= rs2Dep_d[i];
        imm_q[i]    <= imm_d[i];
        pc_q[i]     <= pc_d[i];
      end
    end
  end

  assign bus.out_valid     = outValid_q;
  assign bus.out_op        = outOp_q;
  assign bus.out_rob_index = outRob_q;
  assign bus.out_rs1       = outRs1_q;
  assign bus.out_rs2       = outRs2_q;
  assign bus.out_imm       = outImm_q;
  assign bus.out_PC        = outPc_q;
  assign bus.rs_full       = rsFull;
  assign bus.rs_count      = count_q;

endmodule
